// File: rtl/array_order_checker_pkg.sv
// Shared definitions for the array order checker.
//   state_e           : scan FSM states
//   DEFAULT_BASE_ADDR : byte address of element 0 of the sorted array
//   WORD_STRIDE       : byte distance between consecutive 32-bit words
//   word_addr()       : byte address of a given element index
package array_order_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd4336;
  localparam logic [31:0] WORD_STRIDE       = 32'd4;

  // Byte address of element idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx * WORD_STRIDE);
  endfunction

endpackage

// File: rtl/array_order_checker.sv
// Array order checker: on start, reads NUM_WORDS consecutive words from
// BASE_ADDR through the data-memory read port and reports whether the array
// is non-decreasing, how many adjacent inversions it holds and where the
// first one is.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : single-cycle scan request (honoured only in IDLE)
//   busy            : scan in progress
//   done            : one-cycle completion pulse
//   pass            : 1 = no inversions (valid from done until next start)
//   inversions      : saturating count of i with a[i] > a[i+1]
//   first_bad_idx   : smallest i+1 with a[i] > a[i+1], all-ones if none
//   mem_addr        : byte read address
//   mem_read        : read strobe (data returns the following cycle)
//   mem_rdata       : read data
module array_order_checker
  import array_order_checker_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          NUM_WORDS = 3,
  parameter bit          SIGNED    = 1'b1,
  parameter int          IDX_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] inversions,
  output logic [IDX_W-1:0] first_bad_idx,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  input  logic [31:0]      mem_rdata
);

  localparam logic [IDX_W-1:0] IDX_ONES = {IDX_W{1'b1}};
  localparam logic [31:0]      LAST_IDX = 32'(NUM_WORDS - 1);

  if (NUM_WORDS < 1) begin : g_bad_num_words
    $error("array_order_checker: NUM_WORDS must be >= 1");
  end

  state_e           state_q, state_d;
  logic [31:0]      idx_q, idx_d;
  logic [31:0]      prev_q, prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [IDX_W-1:0] inv_q, inv_d;
  logic [IDX_W-1:0] fbi_q, fbi_d;
  logic [31:0]      addr_q, addr_d;
  logic             read_q, read_d;
  logic             gt_s;

  // Single comparator: previous element strictly greater than the new one.
  if (SIGNED) begin : g_signed_cmp
    assign gt_s = $signed(prev_q) > $signed(mem_rdata);
  end else begin : g_unsigned_cmp
    assign gt_s = prev_q > mem_rdata;
  end

  // Next-state and next-output logic of the scan FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    inv_d   = inv_q;
    fbi_d   = fbi_q;
    addr_d  = addr_q;
    read_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          idx_d   = 32'd0;
          inv_d   = {IDX_W{1'b0}};
          pass_d  = 1'b0;
          fbi_d   = IDX_ONES;
          busy_d  = 1'b1;
          // Outputs are registered, so the strobe for REQ is set up here.
          read_d  = 1'b1;
          addr_d  = word_addr(BASE_ADDR, 32'd0);
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        state_d = CAP;
      end

      CAP: begin
        prev_d = mem_rdata;
        if ((idx_q != 32'd0) && gt_s) begin
          if (inv_q != IDX_ONES) begin
            inv_d = inv_q + IDX_W'(32'd1);
          end else begin
            inv_d = inv_q;
          end
          if (fbi_q == IDX_ONES) begin
            fbi_d = IDX_W'(idx_q);
          end else begin
            fbi_d = fbi_q;
          end
        end else begin
          inv_d = inv_q;
        end

        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          // Uses the count including this last comparison.
          pass_d  = (inv_d == {IDX_W{1'b0}});
        end else begin
          state_d = REQ;
          idx_d   = idx_q + 32'd1;
          read_d  = 1'b1;
          addr_d  = word_addr(BASE_ADDR, idx_q + 32'd1);
        end
      end

      DONE: begin
        // A start seen here is deliberately dropped.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 32'd0;
      prev_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      inv_q   <= {IDX_W{1'b0}};
      fbi_q   <= IDX_ONES;
      addr_q  <= BASE_ADDR;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      inv_q   <= inv_d;
      fbi_q   <= fbi_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign inversions    = inv_q;
  assign first_bad_idx = fbi_q;
  assign mem_addr      = addr_q;
  assign mem_read      = read_q;

endmodule

// File: tb/tb_array_order_checker.sv
// Bench for array_order_checker. Four instances share one word memory:
//   0: NUM_WORDS=3 signed, 1: NUM_WORDS=2 signed, 2: NUM_WORDS=2 unsigned,
//   3: NUM_WORDS=5 signed with 2-bit index/count outputs (saturation).
// Expected results come from a loop over the memory contents.
module tb_array_order_checker;

  localparam logic [31:0] BASE = 32'd4336;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  start_v = 4'd0;
  logic [3:0]  busy_v, done_v, pass_v, read_v;
  logic [31:0] addr_v  [4];
  logic [31:0] rdata_v [4];
  logic [15:0] inv_v   [4];
  logic [15:0] fbi_v   [4];
  logic [1:0]  inv3_w, fbi3_w;
  logic [31:0] mem [0:7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_order_checker #(.NUM_WORDS(3), .SIGNED(1'b1), .IDX_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .inversions(inv_v[0]), .first_bad_idx(fbi_v[0]),
    .mem_addr(addr_v[0]), .mem_read(read_v[0]), .mem_rdata(rdata_v[0]));

  array_order_checker #(.NUM_WORDS(2), .SIGNED(1'b1), .IDX_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .inversions(inv_v[1]), .first_bad_idx(fbi_v[1]),
    .mem_addr(addr_v[1]), .mem_read(read_v[1]), .mem_rdata(rdata_v[1]));

  array_order_checker #(.NUM_WORDS(2), .SIGNED(1'b0), .IDX_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .inversions(inv_v[2]), .first_bad_idx(fbi_v[2]),
    .mem_addr(addr_v[2]), .mem_read(read_v[2]), .mem_rdata(rdata_v[2]));

  array_order_checker #(.NUM_WORDS(5), .SIGNED(1'b1), .IDX_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .inversions(inv3_w), .first_bad_idx(fbi3_w),
    .mem_addr(addr_v[3]), .mem_read(read_v[3]), .mem_rdata(rdata_v[3]));

  assign inv_v[3] = {14'd0, inv3_w};
  assign fbi_v[3] = {14'd0, fbi3_w};

  // Data memory: one-cycle read latency; garbage when no read is issued so
  // a capture in the wrong cycle shows up.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (read_v[k]) rdata_v[k] <= mem[3'((addr_v[k] - BASE) >> 2)];
      else           rdata_v[k] <= $urandom;
    end
  end

  // Reference: count descents over the first n words of memory.
  task automatic ref_model(input int n, input bit sgn, input int w,
                           output bit p, output int inv, output int fbi);
    int ones;
    ones = (1 << w) - 1;
    inv  = 0;
    fbi  = ones;
    for (int i = 0; i + 1 < n; i++) begin
      bit gt;
      gt = sgn ? ($signed(mem[i]) > $signed(mem[i+1])) : (mem[i] > mem[i+1]);
      if (gt) begin
        inv++;
        if (fbi == ones) fbi = i + 1;
      end
    end
    p = (inv == 0);
    if (inv > ones) inv = ones;
  endtask

  // One scan on instance k. mask bit c drives start during cycle c (cycle 1
  // is the cycle after the accept edge).
  task automatic run_scan(input int k, input int n, input int w, input bit sgn,
                          input logic [31:0] mask, input string tag);
    bit   exp_p;
    int   exp_inv, exp_fbi, ones, done_cyc, n_done, n_busy, last;
    logic [31:0] addrs[$];
    bit   held_ok;
    ones = (1 << w) - 1;
    ref_model(n, sgn, w, exp_p, exp_inv, exp_fbi);
    done_cyc = -1; n_done = 0; n_busy = 0; held_ok = 1'b1;
    last = 2 * n + 6;

    @(posedge clk); #1;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      start_v[k] = mask[c];
      if (c == 1) begin
        checks++;
        if (pass_v[k] !== 1'b0 || inv_v[k] !== 16'd0 || fbi_v[k] !== 16'(ones)) begin
          errors++;
          $display("FAIL %s clear_on_start: pass=%b inv=%0d fbi=%0h, want 0 0 %0h",
                   tag, pass_v[k], inv_v[k], fbi_v[k], ones);
        end
      end
      if (read_v[k]) addrs.push_back(addr_v[k]);
      if (busy_v[k]) n_busy++;
      if (done_v[k]) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          checks++;
          if (pass_v[k] !== exp_p || inv_v[k] !== 16'(exp_inv) || fbi_v[k] !== 16'(exp_fbi)) begin
            errors++;
            $display("FAIL %s result: pass=%b inv=%0d fbi=%0h, want %b %0d %0h",
                     tag, pass_v[k], inv_v[k], fbi_v[k], exp_p, exp_inv, exp_fbi);
          end
        end
      end else if (done_cyc > 0) begin
        if (pass_v[k] !== exp_p || inv_v[k] !== 16'(exp_inv) || fbi_v[k] !== 16'(exp_fbi))
          held_ok = 1'b0;
      end
    end
    start_v[k] = 1'b0;

    checks++;
    if (done_cyc != 2 * n + 1 || n_done != 1) begin
      errors++;
      $display("FAIL %s done_timing: cycle=%0d pulses=%0d, want cycle %0d pulses 1",
               tag, done_cyc, n_done, 2 * n + 1);
    end
    checks++;
    if (n_busy != 2 * n) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, want %0d", tag, n_busy, 2 * n);
    end
    checks++;
    if (addrs.size() != n) begin
      errors++;
      $display("FAIL %s read_count: got %0d, want %0d", tag, addrs.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (addrs[i] !== BASE + 32'(4 * i)) begin
          errors++;
          $display("FAIL %s addr[%0d]: got %0d, want %0d", tag, i, addrs[i], BASE + 32'(4 * i));
        end
      end
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL %s results_held: outputs changed after done (now pass=%b inv=%0d fbi=%0h)",
               tag, pass_v[k], inv_v[k], fbi_v[k]);
    end
  endtask

  task automatic load(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] a3, input logic [31:0] a4);
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3; mem[4] = a4;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || pass_v[k] !== 1'b0 ||
          inv_v[k] !== 16'd0 || read_v[k] !== 1'b0 || addr_v[k] !== BASE ||
          fbi_v[k] !== ((k == 3) ? 16'h0003 : 16'hFFFF)) begin
        errors++;
        $display("FAIL reset[%0d]: busy=%b done=%b pass=%b inv=%0d fbi=%0h rd=%b addr=%0d",
                 k, busy_v[k], done_v[k], pass_v[k], inv_v[k], fbi_v[k], read_v[k], addr_v[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sorted();
    load(-32'sd5, 32'd0, 32'd7, 32'd0, 32'd0);
    run_scan(0, 3, 16, 1'b1, 32'd0, "sorted");
  endtask

  task automatic test_reverse();
    load(32'd3, 32'd2, 32'd1, 32'd0, 32'd0);
    run_scan(0, 3, 16, 1'b1, 32'd0, "reverse");
  endtask

  task automatic test_equal();
    load(32'd4, 32'd4, 32'd4, 32'd0, 32'd0);
    run_scan(0, 3, 16, 1'b1, 32'd0, "equal");
  endtask

  task automatic test_signedness();
    load(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
    run_scan(1, 2, 16, 1'b1, 32'd0, "n2_signed");
    run_scan(2, 2, 16, 1'b0, 32'd0, "n2_unsigned");
  endtask

  task automatic test_saturation();
    load(32'd5, 32'd4, 32'd3, 32'd2, 32'd1);
    run_scan(3, 5, 2, 1'b1, 32'd0, "saturate");
    load(32'd1, 32'd1, 32'd0, 32'd9, 32'd8);
    run_scan(3, 5, 2, 1'b1, 32'd0, "n5_two_inv");
  endtask

  task automatic test_reset_mid_scan();
    bit saw_done;
    saw_done = 1'b0;
    load(32'd9, 32'd1, 32'd5, 32'd0, 32'd0);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;   // cycle 1
    start_v[0] = 1'b0;
    @(posedge clk); #1;   // cycle 2
    @(posedge clk); #1;   // cycle 3
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || read_v[0] !== 1'b0 || done_v[0] !== 1'b0 ||
        addr_v[0] !== BASE || fbi_v[0] !== 16'hFFFF || inv_v[0] !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%b rd=%b done=%b addr=%0d fbi=%0h inv=%0d",
               busy_v[0], read_v[0], done_v[0], addr_v[0], fbi_v[0], inv_v[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset_no_done: activity seen after reset, want none");
    end
    load(32'd1, 32'd9, 32'd5, 32'd0, 32'd0);
    run_scan(0, 3, 16, 1'b1, 32'd0, "after_reset");
  endtask

  task automatic test_restart_ignored();
    load(32'd2, 32'd8, 32'd3, 32'd0, 32'd0);
    // start in cycles 2 and 4 (busy) and 7 (DONE): all must be dropped.
    run_scan(0, 3, 16, 1'b1, 32'h0000_0094, "restart_ignored");
  endtask

  task automatic test_back_to_back();
    load(32'd7, 32'd7, 32'd6, 32'd0, 32'd0);
    run_scan(0, 3, 16, 1'b1, 32'd0, "b2b_first");
    load(32'd0, 32'd1, 32'd2, 32'd0, 32'd0);
    run_scan(0, 3, 16, 1'b1, 32'd0, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    pool[0] = 32'd0;         pool[1] = 32'd1;         pool[2] = 32'd2;
    pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h8000_0000; pool[5] = 32'h7FFF_FFFF;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 5; i++) mem[i] = pool[$urandom_range(0, 5)];
      run_scan(0, 3, 16, 1'b1, 32'd0, "rand_n3s");
      run_scan(1, 2, 16, 1'b1, 32'd0, "rand_n2s");
      run_scan(2, 2, 16, 1'b0, 32'd0, "rand_n2u");
      run_scan(3, 5, 2, 1'b1, 32'd0, "rand_n5s");
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    test_reset();
    test_sorted();
    test_reverse();
    test_equal();
    test_signedness();
    test_saturation();
    test_reset_mid_scan();
    test_restart_ignored();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
